// File: rtl/mavg_sched_pkg.sv
// Shared types and defaults for the multi-channel moving-sum scheduler.
// A channel state bundles its sample history ring, running total and write pointer.
package mavg_sched_pkg;

    localparam int NUM_CH_DEFAULT   = 4;
    localparam int WIN_DEFAULT      = 16;
    localparam int SAMPLE_W_DEFAULT = 8;
    localparam int WP_W_DEFAULT     = $clog2(WIN_DEFAULT);

    typedef logic signed [SAMPLE_W_DEFAULT-1:0] sample_t;
    typedef sample_t [WIN_DEFAULT-1:0]          ring_t;

    typedef struct packed {
        ring_t                   ring;
        sample_t                 total;
        logic [WP_W_DEFAULT-1:0] wp;
    } chan_state_t;

    // Running-total update; the result wraps modulo 2^SAMPLE_W by truncation.
    function automatic sample_t mavg_update(sample_t total, sample_t x, sample_t old);
        return total + x - old;
    endfunction

endpackage

// File: rtl/mavg_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, rotating priority.
// rr_ptr holds the highest-priority channel, i.e. last_grant+1 mod NUM_CH.
module mavg_rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic                      system1000,
    input  logic                      system1000_rstn,
    input  logic [NUM_CH-1:0]         req,
    input  logic                      enable,
    output logic [NUM_CH-1:0]         gnt,
    output logic [$clog2(NUM_CH)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_CH);

    logic [IDX_W-1:0] rr_ptr;
    int               cand;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    // Walk from lowest to highest priority so the highest-priority requester wins last.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        cand = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = (int'(rr_ptr) + i) % NUM_CH;
            if (enable && req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            rr_ptr <= '0;
        end else if (|gnt) begin
            rr_ptr <= (idx == IDX_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/mavg_channel_scheduler.sv
// Time-multiplexed 16-tap moving sum shared across NUM_CH requesters.
// One sample per cycle is granted round-robin; result appears one cycle later.
module mavg_channel_scheduler
    import mavg_sched_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEFAULT,
    parameter int WIN      = WIN_DEFAULT,
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
    input  logic                        system1000,
    input  logic                        system1000_rstn,
    input  logic [NUM_CH-1:0]           req_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]  req_data,
    output logic [NUM_CH-1:0]           req_ready,
    input  logic                        clr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(NUM_CH)-1:0]   out_ch,
    output logic signed [SAMPLE_W-1:0]  out_data
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int WP_W = $clog2(WIN);

    chan_state_t       chan [NUM_CH];
    chan_state_t       sel;
    logic              stall;
    logic              arb_en;
    logic              accept;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    sample_t           in_x;
    sample_t           old_x;
    sample_t           new_total;

    // Grants are also masked during reset so req_ready reads 0 while held in reset.
    assign stall  = out_valid & ~out_ready;
    assign arb_en = system1000_rstn & ~stall & ~clr;

    mavg_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .req             (req_valid),
        .enable          (arb_en),
        .gnt             (gnt),
        .idx             (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    // Shared datapath: one channel's state is selected by the grant index.
    assign sel       = chan[gnt_idx];
    assign in_x      = sample_t'(req_data[gnt_idx*SAMPLE_W +: SAMPLE_W]);
    assign old_x     = sel.ring[sel.wp];
    assign new_total = mavg_update(sel.total, in_x, old_x);

    // NOTE: the history rings are reset explicitly; stale entries would corrupt the first sums.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int k = 0; k < NUM_CH; k++) begin
                chan[k] <= '0;
            end
        end else if (clr) begin
            for (int k = 0; k < NUM_CH; k++) begin
                chan[k] <= '0;
            end
        end else if (accept) begin
            chan[gnt_idx].ring[sel.wp] <= in_x;
            chan[gnt_idx].wp           <= sel.wp + WP_W'(1);
            chan[gnt_idx].total        <= new_total;
        end
    end

    // Output register: loads on accept, holds under stall, drops valid once taken.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_ch    <= gnt_idx;
            out_data  <= new_total;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mavg_channel_scheduler.sv
// Scoreboard bench: per-channel sample-history model feeds an expected-result
// queue that a separate negedge monitor drains as the DUT presents results.
module tb_mavg_channel_scheduler;

    localparam int NUM_CH   = 4;
    localparam int WIN      = 16;
    localparam int SAMPLE_W = 8;

    typedef struct {
        int                  ch;
        logic signed [7:0]   data;
    } exp_t;

    logic                       system1000;
    logic                       system1000_rstn;
    logic [NUM_CH-1:0]          req_valid;
    logic [NUM_CH*SAMPLE_W-1:0] req_data;
    logic [NUM_CH-1:0]          req_ready;
    logic                       clr;
    logic                       out_valid;
    logic                       out_ready;
    logic [1:0]                 out_ch;
    logic signed [7:0]          out_data;

    mavg_channel_scheduler #(
        .NUM_CH   (NUM_CH),
        .WIN      (WIN),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .clr             (clr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_ch          (out_ch),
        .out_data        (out_data)
    );

    initial begin
        system1000 = 1'b0;
        forever #5 system1000 = ~system1000;
    end

    int checks = 0;
    int errors = 0;

    // Reference state: last WIN accepted samples per channel, rr priority, expected valid.
    int   hist [NUM_CH][$];
    int   rr_next = 0;
    bit   exp_ov = 1'b0;
    exp_t q [$];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [7:0] win_sum(input int ch);
        int s = 0;
        foreach (hist[ch][i]) s += hist[ch][i];
        return 8'(s);
    endfunction

    function automatic logic [31:0] pack1(input int ch, input int x);
        logic [31:0] d = '0;
        d[ch*8 +: 8] = 8'(x);
        return d;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) hist[k].delete();
        rr_next = 0;
        exp_ov  = 1'b0;
        q.delete();
    endtask

    // One clock cycle; entered and left at posedge+2.
    task automatic step(input logic [3:0] v, input logic [31:0] d, input bit rdy,
                        input bit c, input bit chk, input logic signed [7:0] cv);
        int g;
        int exp_gnt;
        int x;
        req_valid = v;
        req_data  = d;
        out_ready = rdy;
        clr       = c;
        @(negedge system1000);
        g = -1;
        if (!c && !(exp_ov && !rdy)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (g < 0 && v[(rr_next + i) % NUM_CH]) g = (rr_next + i) % NUM_CH;
            end
        end
        exp_gnt = (g >= 0) ? (1 << g) : 0;
        check("req_ready", req_ready, exp_gnt);
        if (chk) check("out_data_direct", out_data, cv);
        @(posedge system1000);
        if (c) for (int k = 0; k < NUM_CH; k++) hist[k].delete();
        if (g >= 0) begin
            x = int'($signed(d[g*8 +: 8]));
            hist[g].push_back(x);
            if (hist[g].size() > WIN) void'(hist[g].pop_front());
            rr_next = (g + 1) % NUM_CH;
            q.push_back('{ch: g, data: win_sum(g)});
            exp_ov = 1'b1;
        end else if (rdy) begin
            exp_ov = 1'b0;
        end
        #2;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard head.
    initial begin
        forever begin
            @(negedge system1000);
            if (system1000_rstn) begin
                check("out_valid", out_valid, exp_ov);
                if (out_valid) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected: ch %0d data %0d with empty scoreboard", out_ch, out_data);
                    end else begin
                        check("out_ch", out_ch, q[0].ch);
                        check("out_data", out_data, q[0].data);
                        if (out_ready) void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        system1000_rstn = 1'b0;
        req_valid = 4'hF;
        req_data  = '0;
        clr       = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_data", out_data, 0);
        req_valid = '0;
        #10 system1000_rstn = 1'b1;
        @(posedge system1000);
        #2;

        // ch0 sends 1..16, then 17 evicts the oldest sample.
        for (int i = 1; i <= 16; i++) step(4'b0001, pack1(0, i), 1, 0, 0, 0);
        step(4'b0000, 0, 1, 0, 1, -120);
        step(4'b0001, pack1(0, 17), 1, 0, 0, 0);
        step(4'b0000, 0, 1, 0, 1, -104);

        // All channels request together: rotating grants.
        for (int i = 0; i < 8; i++) step(4'hF, $urandom, 1, 0, 0, 0);

        // Downstream stall with requests pending, then resume.
        step(4'hF, $urandom, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(4'hF, $urandom, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(4'hF, $urandom, 1, 0, 0, 0);

        // Clear with ch2 holding sum 50: no accept during clr, fresh sum afterwards.
        step(4'b0000, 0, 1, 1, 0, 0);
        step(4'b0100, pack1(2, 20), 1, 0, 0, 0);
        step(4'b0100, pack1(2, 30), 1, 0, 0, 0);
        step(4'b0000, 0, 1, 0, 1, 50);
        step(4'b0100, pack1(2, 9), 1, 1, 0, 0);
        step(4'b0100, pack1(2, 5), 1, 0, 0, 0);
        step(4'b0000, 0, 1, 0, 1, 5);

        // Randomized traffic with stalls and occasional clears.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), $urandom, ($urandom_range(3) != 0), ($urandom_range(39) == 0), 0, 0);
        end

        // Asynchronous reset while a result is pending.
        step(4'b0010, pack1(1, 7), 0, 0, 0, 0);
        req_valid = 4'hF;
        system1000_rstn = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_req_ready", req_ready, 0);
        model_reset();
        req_valid = '0;
        #3 system1000_rstn = 1'b1;
        @(posedge system1000);
        #2;
        step(4'b0001, pack1(0, -3), 1, 0, 0, 0);
        step(4'b0000, 0, 1, 0, 1, -3);

        // Drain, bounded.
        for (int i = 0; i < 20 && q.size() != 0; i++) step(4'b0000, 0, 1, 0, 0, 0);
        check("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
